pong_playfield: RTL and testbench
=================================

Name: pong_playfield

Overview:
- Graphics and game-physics core of the VGA Pong design for a 640x480 display.
- Debounces the two players' raw 2-bit button inputs and moves two paddles and a ball once per frame.
- Detects paddle hits and misses, and keeps two-digit BCD scores for the score text renderer.
- Produces an object-on flag and 3-bit RGB for the current pixel, which the top-level colour mux consumes.

Parameters:
- DB_BITS, 20, debounce counter width; an input must be stable for 2^DB_BITS clocks before it is accepted.
- PAD_V, 4, paddle speed in pixels per frame.
- BALL_V, 2, ball speed per axis in pixels per frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-low (0 = reset)
- btn1  in  2  raw left-player buttons; [1]=up, [0]=down
- btn2  in  2  raw right-player buttons; [1]=up, [0]=down
- pix_x  in  10  current pixel column, 0..799
- pix_y  in  10  current pixel row, 0..524
- graph_still  in  1  1 = hold the ball at centre and freeze motion
- btn1_db  out  2  debounced btn1
- btn2_db  out  2  debounced btn2
- graph_on  out  1  the current pixel lies on a paddle or the ball
- graph_rgb  out  3  object colour; 000 when graph_on=0
- hit_left  out  1  1-clk pulse: ball bounced off the left paddle
- hit_right  out  1  1-clk pulse: ball bounced off the right paddle
- miss  out  1  1-clk pulse: ball passed a paddle
- left_score  out  8  BCD; [7:4] tens, [3:0] units
- right_score  out  8  BCD; [7:4] tens, [3:0] units

Behaviour:
- Clock and reset
  - All registers are clocked by clk. Reset is sampled only at the clk edge while reset=0.
  - Reset values: paddle tops = 204; ball x=316, y=236; vx=+BALL_V, vy=+BALL_V; scores=00; debounced outputs=0; pulses=0.
- Debounce (one instance per button bit)
  - Two-flop synchroniser, then a counter that clears whenever the synchronised input differs from the output.
  - The output takes the input value when the counter saturates at 2^DB_BITS-1.
  - Latency is 2^DB_BITS+2 clocks.
- Frame tick
  - refr_tick is 1 for one clock when pix_y==481 and pix_x==0.
  - All motion, collision, pulse and score updates happen only on refr_tick.
- Paddles
  - Each paddle is 4 wide and 72 tall. Left paddle spans x 32..35; right paddle spans x 600..603.
  - On refr_tick, if only up is pressed and top > PAD_V, top decreases by PAD_V.
  - On refr_tick, if only down is pressed and top+71 < 479-PAD_V, top increases by PAD_V.
  - Both pressed or neither pressed: the paddle does not move.
  - Paddles also move while graph_still=1.
- Ball: 8x8 square with top-left corner (bx,by).
  - While graph_still=1: (bx,by)=(316,236), vx=+BALL_V, vy=+BALL_V, and no pulses are generated.
  - Otherwise, on refr_tick, evaluate in this priority:
    - by <= 1: vy=+BALL_V.
    - by+7 >= 478: vy=-BALL_V.
    - bx in 32..35 and the ball's y span overlaps the left paddle, and vx<0: vx=+BALL_V, hit_left=1.
    - bx+7 in 600..603 with y overlap, and vx>0: vx=-BALL_V, hit_right=1.
    - bx < 4 (left miss) or bx+7 > 635 (right miss): miss=1.
  - The ball then moves by (vx,vy) using the updated velocity.
  - After a miss the ball keeps moving until the top level asserts graph_still.
- Scores
  - A left miss increments right_score; a right miss increments left_score.
  - BCD increment: units 9 goes to 0 with a carry into tens; 99 wraps to 00.
  - Scores clear only on reset.
- Pixel output (combinational from pix_x, pix_y and the current registers)
  - Colours: left paddle 010, right paddle 001, ball 100.
  - The ball has priority over paddles.
  - graph_on is the OR of the three object hits.
  - For pix_x >= 640 or pix_y >= 480, graph_on=0.

Decomposition:
- Shared package pong_pkg: screen constants (640, 480, refresh row 481), paddle x-ranges, paddle height 72, ball size 8, and colour codes.
- One sub-module, pong_debouncer, instantiated 4 times.
- Paddles, ball and scores stay in pong_playfield.

Test Plan:
- Reset and pixel output: hold reset=0 for 2 clk, then release. Check scores=00 and ball at (316,236). Drive pix_x=316, pix_y=236: graph_on=1, rgb=100. Drive pix_x=34, pix_y=204: rgb=010.
- Debounce (DB_BITS=3):
  - A 5-clk glitch on btn1[1] leaves btn1_db=0.
  - A level held for 12 clk sets btn1_db[1]=1 within 10 clk.
- Paddle motion and limits: hold btn1 up for 60 frames. Left top steps 204,200,... down to 4 and then stays. Pressing up and down together leaves it still.
- Bounce: with graph_still=0, run frames until by+7 >= 478. Next frame vy=-2 and by decreases by 2.
- Paddle hit: hold the left paddle at top 204, start from reset and run frames. When bx reaches 34 with vx<0, expect hit_left for exactly 1 clk, after which vx=+2.
- Miss and score: remove the right paddle's overlap so the ball escapes right. Expect miss=1 for 1 clk and left_score 00->01. Preload left_score to 09 or 99 and check 10 and 00 respectively. Assert graph_still and check the ball snaps to (316,236).

Source files
------------

// File: rtl/pong_pkg.sv
// Shared screen geometry, object colours and small arithmetic helpers for the
// Pong playfield and its debouncers.
package pong_pkg;

  typedef logic [9:0]  coord_t;
  typedef logic [10:0] coord_ext_t;

  localparam coord_t SCR_W     = 10'd640;
  localparam coord_t SCR_H     = 10'd480;
  localparam coord_t REFR_ROW  = 10'd481;

  localparam coord_t LPAD_XL   = 10'd32;
  localparam coord_t LPAD_XR   = 10'd35;
  localparam coord_t RPAD_XL   = 10'd600;
  localparam coord_t RPAD_XR   = 10'd603;
  localparam coord_t PAD_H     = 10'd72;
  localparam coord_t PAD_TOP0  = 10'd204;
  localparam coord_t PAD_FLOOR = 10'd479;

  localparam coord_t BALL_SIZE = 10'd8;
  localparam coord_t BALL_X0   = 10'd316;
  localparam coord_t BALL_Y0   = 10'd236;
  localparam coord_t BALL_Y_MIN = 10'd1;
  localparam coord_t BALL_Y_MAX = 10'd478;
  localparam coord_t MISS_XL   = 10'd4;
  localparam coord_t MISS_XR   = 10'd635;

  typedef enum logic [2:0] {
    RGB_NONE = 3'b000,
    RGB_RPAD = 3'b001,
    RGB_LPAD = 3'b010,
    RGB_BALL = 3'b100
  } rgb_e;

  function automatic coord_ext_t ext(input coord_t v);
    return {1'b0, v};
  endfunction

  function automatic logic in_range(input coord_ext_t v, input coord_ext_t lo, input coord_ext_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic overlap(input coord_ext_t a_lo, input coord_ext_t a_hi,
                                   input coord_ext_t b_lo, input coord_ext_t b_hi);
    return (a_lo <= b_hi) && (a_hi >= b_lo);
  endfunction

  // btn is {up, down}; a paddle only moves when exactly one of them is held.
  function automatic coord_t pad_step(input coord_t top, input logic [1:0] btn, input coord_t v);
    coord_ext_t bottom;
    bottom = ext(top) + ext(PAD_H) - 11'd1;
    if ((btn == 2'b10) && (top > v)) begin
      return top - v;
    end else if ((btn == 2'b01) && (bottom < (ext(PAD_FLOOR) - ext(v)))) begin
      return top + v;
    end else begin
      return top;
    end
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = s[7:4];
    units = s[3:0];
    if (units >= 4'd9) begin
      units = 4'd0;
      if (tens >= 4'd9) begin
        tens = 4'd0;
      end else begin
        tens = tens + 4'd1;
      end
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/pong_playfield_if.sv
// Pixel-side bus between the video timing/colour mux and the playfield.
interface pong_playfield_if;
  import pong_pkg::*;

  coord_t     pix_x;
  coord_t     pix_y;
  logic       graph_on;
  logic [2:0] graph_rgb;

  modport master (output pix_x, pix_y, input graph_on, graph_rgb);
  modport slave  (input pix_x, pix_y, output graph_on, graph_rgb);
endinterface

// File: rtl/pong_debouncer.sv
// Button debouncer: two-flop synchroniser followed by a stability counter;
// the output follows the input once it has differed for 2^DB_BITS clocks.
module pong_debouncer #(
  parameter int DB_BITS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic               sync1_r;
  logic               sync2_r;
  logic [DB_BITS-1:0] cnt_r;

  // Counter runs only while the synchronised input disagrees with the output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= '0;
      dout    <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      if (sync2_r == dout) begin
        cnt_r <= '0;
      end else if (&cnt_r) begin
        dout  <= sync2_r;
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + DB_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/pong_playfield.sv
// Pong game physics and object renderer: debounced paddles, a bouncing ball,
// hit/miss pulses and BCD scores, all advanced once per frame.
module pong_playfield
  import pong_pkg::*;
#(
  parameter int DB_BITS = 20,
  parameter int PAD_V   = 4,
  parameter int BALL_V  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  btn1,
  input  logic [1:0]  btn2,
  input  logic        graph_still,
  output logic [1:0]  btn1_db,
  output logic [1:0]  btn2_db,
  output logic        hit_left,
  output logic        hit_right,
  output logic        miss,
  output logic [7:0]  left_score,
  output logic [7:0]  right_score,
  pong_playfield_if.slave vid
);

  localparam coord_t PV = 10'(PAD_V);
  localparam coord_t BV = 10'(BALL_V);

  for (genvar i = 0; i < 2; i++) begin : g_db
    pong_debouncer #(.DB_BITS(DB_BITS)) u_db1 (.clk(clk), .reset(reset), .din(btn1[i]), .dout(btn1_db[i]));
    pong_debouncer #(.DB_BITS(DB_BITS)) u_db2 (.clk(clk), .reset(reset), .din(btn2[i]), .dout(btn2_db[i]));
  end

  coord_t     lpad_top_r, rpad_top_r, bx_r, by_r;
  logic       vx_neg_r, vy_neg_r;
  coord_t     lpad_top_n, rpad_top_n, bx_n, by_n;
  logic       vx_neg_n, vy_neg_n;
  logic       hit_left_n, hit_right_n, miss_left_n, miss_right_n;
  logic [7:0] left_score_n, right_score_n;
  logic       tick_s, lov_s, rov_s;
  coord_ext_t bx_end_s, by_end_s;

  assign tick_s   = (vid.pix_y == REFR_ROW) && (vid.pix_x == 10'd0);
  assign bx_end_s = ext(bx_r) + ext(BALL_SIZE) - 11'd1;
  assign by_end_s = ext(by_r) + ext(BALL_SIZE) - 11'd1;
  assign lov_s = overlap(ext(by_r), by_end_s, ext(lpad_top_r), ext(lpad_top_r) + ext(PAD_H) - 11'd1);
  assign rov_s = overlap(ext(by_r), by_end_s, ext(rpad_top_r), ext(rpad_top_r) + ext(PAD_H) - 11'd1);

  // Paddles keep responding while the ball is held at centre.
  assign lpad_top_n = tick_s ? pad_step(lpad_top_r, btn1_db, PV) : lpad_top_r;
  assign rpad_top_n = tick_s ? pad_step(rpad_top_r, btn2_db, PV) : rpad_top_r;

  // Ball physics: one prioritised event per frame, then move with the new velocity.
  always_comb begin
    bx_n         = bx_r;
    by_n         = by_r;
    vx_neg_n     = vx_neg_r;
    vy_neg_n     = vy_neg_r;
    hit_left_n   = 1'b0;
    hit_right_n  = 1'b0;
    miss_left_n  = 1'b0;
    miss_right_n = 1'b0;
    if (graph_still) begin
      bx_n     = BALL_X0;
      by_n     = BALL_Y0;
      vx_neg_n = 1'b0;
      vy_neg_n = 1'b0;
    end else if (tick_s) begin
      if (by_r <= BALL_Y_MIN) begin
        vy_neg_n = 1'b0;
      end else if (by_end_s >= ext(BALL_Y_MAX)) begin
        vy_neg_n = 1'b1;
      end else if (in_range(ext(bx_r), ext(LPAD_XL), ext(LPAD_XR)) && lov_s && vx_neg_r) begin
        vx_neg_n   = 1'b0;
        hit_left_n = 1'b1;
      end else if (in_range(bx_end_s, ext(RPAD_XL), ext(RPAD_XR)) && rov_s && !vx_neg_r) begin
        vx_neg_n    = 1'b1;
        hit_right_n = 1'b1;
      end else if (bx_r < MISS_XL) begin
        miss_left_n = 1'b1;
      end else if (bx_end_s > ext(MISS_XR)) begin
        miss_right_n = 1'b1;
      end else begin
        miss_right_n = 1'b0;
      end
      bx_n = vx_neg_n ? (bx_r - BV) : (bx_r + BV);
      by_n = vy_neg_n ? (by_r - BV) : (by_r + BV);
    end else begin
      bx_n = bx_r;
      by_n = by_r;
    end
  end

  // A ball lost on one side scores a point for the opposite player.
  assign right_score_n = miss_left_n  ? bcd_inc(right_score) : right_score;
  assign left_score_n  = miss_right_n ? bcd_inc(left_score)  : left_score;

  // Game state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lpad_top_r  <= PAD_TOP0;
      rpad_top_r  <= PAD_TOP0;
      bx_r        <= BALL_X0;
      by_r        <= BALL_Y0;
      vx_neg_r    <= 1'b0;
      vy_neg_r    <= 1'b0;
      hit_left    <= 1'b0;
      hit_right   <= 1'b0;
      miss        <= 1'b0;
      left_score  <= 8'h00;
      right_score <= 8'h00;
    end else begin
      lpad_top_r  <= lpad_top_n;
      rpad_top_r  <= rpad_top_n;
      bx_r        <= bx_n;
      by_r        <= by_n;
      vx_neg_r    <= vx_neg_n;
      vy_neg_r    <= vy_neg_n;
      hit_left    <= hit_left_n;
      hit_right   <= hit_right_n;
      miss        <= miss_left_n | miss_right_n;
      left_score  <= left_score_n;
      right_score <= right_score_n;
    end
  end

  logic in_scr_s, ball_on_s, lpad_on_s, rpad_on_s;
  rgb_e rgb_s;

  // Pixel renderer; the ball is drawn over the paddles.
  always_comb begin
    in_scr_s  = (vid.pix_x < SCR_W) && (vid.pix_y < SCR_H);
    ball_on_s = in_scr_s && in_range(ext(vid.pix_x), ext(bx_r), bx_end_s)
                         && in_range(ext(vid.pix_y), ext(by_r), by_end_s);
    lpad_on_s = in_scr_s && in_range(ext(vid.pix_x), ext(LPAD_XL), ext(LPAD_XR))
                         && in_range(ext(vid.pix_y), ext(lpad_top_r), ext(lpad_top_r) + ext(PAD_H) - 11'd1);
    rpad_on_s = in_scr_s && in_range(ext(vid.pix_x), ext(RPAD_XL), ext(RPAD_XR))
                         && in_range(ext(vid.pix_y), ext(rpad_top_r), ext(rpad_top_r) + ext(PAD_H) - 11'd1);
    if (ball_on_s) begin
      rgb_s = RGB_BALL;
    end else if (lpad_on_s) begin
      rgb_s = RGB_LPAD;
    end else if (rpad_on_s) begin
      rgb_s = RGB_RPAD;
    end else begin
      rgb_s = RGB_NONE;
    end
  end

  assign vid.graph_on  = ball_on_s | lpad_on_s | rpad_on_s;
  assign vid.graph_rgb = rgb_s;

endmodule

// File: tb/tb_pong_playfield.sv
// Directed bench for pong_playfield: pixel table, debounce timing, paddle
// limits, ball trajectories with bounces/hits/misses and BCD score wrap.
module tb_pong_playfield;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] btn1 = 2'b00;
  logic [1:0] btn2 = 2'b00;
  logic       graph_still = 1'b1;
  logic [1:0] btn1_db, btn2_db;
  logic       hit_left, hit_right, miss;
  logic [7:0] left_score, right_score;

  int n_vec = 0;
  int n_err = 0;

  pong_playfield_if vid ();

  pong_playfield #(.DB_BITS(3), .PAD_V(4), .BALL_V(2)) dut (
    .clk(clk), .reset(reset), .btn1(btn1), .btn2(btn2), .graph_still(graph_still),
    .btn1_db(btn1_db), .btn2_db(btn2_db), .hit_left(hit_left), .hit_right(hit_right),
    .miss(miss), .left_score(left_score), .right_score(right_score), .vid(vid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         x;
    int         y;
    logic       on;
    logic [2:0] rgb;
  } pix_vec_t;

  pix_vec_t pv [16];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    vid.pix_x = 10'd0;
    vid.pix_y = 10'd481;
    @(posedge clk);
    #1;
    vid.pix_y = 10'd0;
  endtask

  task automatic probe(input int x, input int y, output logic on, output logic [2:0] rgb);
    vid.pix_x = 10'(x);
    vid.pix_y = 10'(y);
    #1;
    on  = vid.graph_on;
    rgb = vid.graph_rgb;
    vid.pix_x = 10'd0;
    vid.pix_y = 10'd0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
  endtask

  task automatic check_ball(input int x, input int y);
    logic on;
    logic [2:0] rgb;
    probe(x, y, on, rgb);          chk("ball_top_left", int'(rgb), 4);
    probe(x + 7, y + 7, on, rgb);  chk("ball_bot_right", int'(rgb), 4);
    probe(x - 1, y, on, rgb);      chk("ball_left_edge", int'(rgb == 3'b100), 0);
    probe(x, y - 1, on, rgb);      chk("ball_top_edge", int'(rgb == 3'b100), 0);
  endtask

  task automatic check_lpad(input int top);
    logic on;
    logic [2:0] rgb;
    probe(33, top, on, rgb);     chk("lpad_top_rgb", int'(rgb), 2);
    probe(33, top - 1, on, rgb); chk("lpad_above_on", int'(on), 0);
  endtask

  task automatic check_rpad(input int top);
    logic on;
    logic [2:0] rgb;
    probe(601, top + 71, on, rgb); chk("rpad_bottom_rgb", int'(rgb), 1);
    probe(601, top + 72, on, rgb); chk("rpad_below_on", int'(on), 0);
  endtask

  function automatic int to_bcd(input int n);
    return (((n % 100) / 10) << 4) | (n % 10);
  endfunction

  task automatic run_traj(input bit move_left);
    int last;
    logic on;
    logic [2:0] rgb;
    bit e_hl, e_hr, e_m;
    do_reset();
    graph_still = 1'b0;
    btn1 = 2'b00;
    btn2 = 2'b01;
    idle(12);
    last = move_left ? 421 : 436;
    for (int k = 0; k <= last; k++) begin
      if (move_left && k == 200) begin btn1 = 2'b10; idle(12); end
      if (move_left && k == 217) begin btn1 = 2'b00; idle(12); end
      if (k == 118) check_ball(552, 472);
      if (k == 119) check_ball(554, 470);
      if (k == 120) check_ball(556, 468);
      if (k == 140) begin check_ball(592, 428); check_rpad(404); end
      if (move_left && k == 419) begin
        check_ball(34, 130);
        check_lpad(136);
        probe(34, 136, on, rgb);
        chk("ball_over_paddle", int'(rgb), 4);
      end
      if (move_left && k == 420) check_ball(36, 132);
      frame();
      e_hl = move_left && (k == 419);
      e_hr = (k == 139);
      e_m  = !move_left && (k == 435 || k == 436);
      chk($sformatf("pulses_f%0d", k), int'({hit_left, hit_right, miss}), int'({e_hl, e_hr, e_m}));
      if (e_hl || e_hr || e_m) begin
        idle(1);
        chk("pulse_width", int'({hit_left, hit_right, miss}), 0);
      end
    end
    chk("traj_left_score", int'(left_score), 0);
    chk("traj_right_score", int'(right_score), move_left ? 0 : 2);
  endtask

  initial begin
    logic on;
    logic [2:0] rgb;
    int n;
    bit seen;

    vid.pix_x = 10'd0;
    vid.pix_y = 10'd0;

    pv[0]  = '{316, 236, 1'b1, 3'b100};
    pv[1]  = '{323, 243, 1'b1, 3'b100};
    pv[2]  = '{324, 243, 1'b0, 3'b000};
    pv[3]  = '{315, 236, 1'b0, 3'b000};
    pv[4]  = '{34,  204, 1'b1, 3'b010};
    pv[5]  = '{32,  275, 1'b1, 3'b010};
    pv[6]  = '{35,  276, 1'b0, 3'b000};
    pv[7]  = '{36,  240, 1'b0, 3'b000};
    pv[8]  = '{600, 204, 1'b1, 3'b001};
    pv[9]  = '{603, 275, 1'b1, 3'b001};
    pv[10] = '{601, 203, 1'b0, 3'b000};
    pv[11] = '{604, 240, 1'b0, 3'b000};
    pv[12] = '{700, 240, 1'b0, 3'b000};
    pv[13] = '{320, 500, 1'b0, 3'b000};
    pv[14] = '{100, 100, 1'b0, 3'b000};
    pv[15] = '{640, 240, 1'b0, 3'b000};

    // Reset state and pixel table
    do_reset();
    chk("rst_left_score", int'(left_score), 0);
    chk("rst_right_score", int'(right_score), 0);
    chk("rst_pulses", int'({hit_left, hit_right, miss}), 0);
    chk("rst_db", int'({btn1_db, btn2_db}), 0);
    for (int i = 0; i < 16; i++) begin
      probe(pv[i].x, pv[i].y, on, rgb);
      chk($sformatf("pix%0d_on", i), int'(on), int'(pv[i].on));
      chk($sformatf("pix%0d_rgb", i), int'(rgb), int'(pv[i].rgb));
    end

    // Debounce: short glitch rejected, held level accepted after 10 clocks
    btn1 = 2'b10;
    idle(5);
    btn1 = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      idle(1);
      seen = seen | (|btn1_db);
    end
    chk("glitch_rejected", int'(seen), 0);
    btn1 = 2'b10;
    n = 0;
    do begin
      idle(1);
      n++;
    end while (btn1_db[1] !== 1'b1 && n < 20);
    chk("db_latency", n, 10);
    chk("db_value", int'(btn1_db), 2);
    btn1 = 2'b00;
    btn2 = 2'b01;
    idle(12);
    chk("db_release", int'(btn1_db), 0);
    chk("db_btn2", int'(btn2_db), 1);
    btn2 = 2'b00;
    idle(12);
    chk("db_btn2_release", int'(btn2_db), 0);

    // Paddle motion and limits, ball held at centre
    do_reset();
    graph_still = 1'b1;
    btn1 = 2'b10;
    btn2 = 2'b01;
    idle(12);
    for (int i = 1; i <= 60; i++) begin
      frame();
      chk("still_pulses", int'({hit_left, hit_right, miss}), 0);
      check_lpad((204 - 4 * i) > 4 ? (204 - 4 * i) : 4);
      check_rpad((204 + 4 * i) < 404 ? (204 + 4 * i) : 404);
    end
    check_ball(316, 236);
    btn1 = 2'b11;
    btn2 = 2'b11;
    idle(12);
    repeat (3) frame();
    check_lpad(4);
    check_rpad(404);
    btn1 = 2'b00;
    btn2 = 2'b00;

    // Bounce, right hit, top bounce, then left hit or left miss
    run_traj(1'b1);
    run_traj(1'b0);

    // Right miss and left score BCD counting through 09->10 and 99->00
    do_reset();
    btn1 = 2'b00;
    btn2 = 2'b00;
    graph_still = 1'b0;
    idle(12);
    for (int k = 0; k <= 256; k++) begin
      frame();
      chk($sformatf("miss_f%0d", k), int'({hit_left, hit_right, miss}), (k >= 157) ? 1 : 0);
      chk($sformatf("lscore_f%0d", k), int'(left_score), to_bcd((k >= 157) ? (k - 156) : 0));
    end
    chk("rscore_after_misses", int'(right_score), 0);
    graph_still = 1'b1;
    idle(1);
    check_ball(316, 236);
    frame();
    chk("still_no_pulse", int'({hit_left, hit_right, miss}), 0);
    chk("still_score_held", int'(left_score), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
